// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline: ID/EX register, operand forwarding,
// ALU, branch/jump resolution and EX/MEM register.
module execute_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [3:0]      ALUControlD,
  input  logic [2:0]      funct3D,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [1:0]      ResultSrcE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic [2:0]      funct3M
);

  localparam int unsigned ShW = $clog2(XLEN);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [3:0]      alu_control;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } id_ex_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic [2:0]      funct3;
  } ex_mem_t;

  id_ex_t  id_ex_q, id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;

  logic [XLEN-1:0] src_a, src_b, write_data, alu_result;
  logic [ShW-1:0]  shamt;
  logic            cond;

  // ID/EX next state: flush beats stall, stall holds, otherwise load from decode
  always_comb begin
    id_ex_d = id_ex_q;
    if (FlushE) begin
      id_ex_d = '0;
    end else if (!StallE) begin
      id_ex_d.reg_write   = RegWriteD;
      id_ex_d.mem_write   = MemWriteD;
      id_ex_d.jump        = JumpD;
      id_ex_d.branch      = BranchD;
      id_ex_d.alu_src     = ALUSrcD;
      id_ex_d.result_src  = ResultSrcD;
      id_ex_d.alu_control = ALUControlD;
      id_ex_d.funct3      = funct3D;
      id_ex_d.rd1         = RD1D;
      id_ex_d.rd2         = RD2D;
      id_ex_d.pc          = PCD;
      id_ex_d.pc_plus4    = PCPlus4D;
      id_ex_d.imm_ext     = ImmExtD;
      id_ex_d.rs1         = Rs1D;
      id_ex_d.rs2         = Rs2D;
      id_ex_d.rd          = RdD;
    end
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (reset) id_ex_q <= '0;
    else       id_ex_q <= id_ex_d;
  end

  // Forwarding muxes for both operands and ALU B-source select
  always_comb begin
    unique case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = id_ex_q.rd1;
    endcase
    unique case (ForwardBE)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = ALUResultM;
      default: write_data = id_ex_q.rd2;
    endcase
    src_b = id_ex_q.alu_src ? id_ex_q.imm_ext : write_data;
  end

  assign shamt = src_b[ShW-1:0];

  // ALU; undefined control codes produce zero
  always_comb begin
    alu_result = '0;
    case (id_ex_q.alu_control)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b0110: alu_result = src_a << shamt;
      4'b0111: alu_result = src_a >> shamt;
      4'b1000: alu_result = $unsigned($signed(src_a) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  // Branch condition on forwarded operands; 010/011 never taken
  always_comb begin
    cond = 1'b0;
    case (id_ex_q.funct3)
      3'b000:  cond = (src_a == src_b);
      3'b001:  cond = (src_a != src_b);
      3'b100:  cond = ($signed(src_a) < $signed(src_b));
      3'b101:  cond = ($signed(src_a) >= $signed(src_b));
      3'b110:  cond = (src_a < src_b);
      3'b111:  cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE    = id_ex_q.jump | (id_ex_q.branch & cond);
  assign PCTargetE = id_ex_q.pc + id_ex_q.imm_ext;

  // EX/MEM next state: a stalled E instruction is held, so send a bubble instead
  always_comb begin
    ex_mem_d = '0;
    if (!StallE) begin
      ex_mem_d.reg_write  = id_ex_q.reg_write;
      ex_mem_d.mem_write  = id_ex_q.mem_write;
      ex_mem_d.result_src = id_ex_q.result_src;
      ex_mem_d.alu_result = alu_result;
      ex_mem_d.write_data = write_data;
      ex_mem_d.pc_plus4   = id_ex_q.pc_plus4;
      ex_mem_d.rd         = id_ex_q.rd;
      ex_mem_d.funct3     = id_ex_q.funct3;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (reset) ex_mem_q <= '0;
    else       ex_mem_q <= ex_mem_d;
  end

  assign Rs1E       = id_ex_q.rs1;
  assign Rs2E       = id_ex_q.rs2;
  assign RdE        = id_ex_q.rd;
  assign ResultSrcE = id_ex_q.result_src;
  assign RegWriteM  = ex_mem_q.reg_write;
  assign MemWriteM  = ex_mem_q.mem_write;
  assign ResultSrcM = ex_mem_q.result_src;
  assign ALUResultM = ex_mem_q.alu_result;
  assign WriteDataM = ex_mem_q.write_data;
  assign PCPlus4M   = ex_mem_q.pc_plus4;
  assign RdM        = ex_mem_q.rd;
  assign funct3M    = ex_mem_q.funct3;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus random traffic, all checked
// against a cycle-level instruction model of the E and M stages.
module tb_execute_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, StallE, FlushE;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD, ForwardAE, ForwardBE;
  logic [3:0]  ALUControlD;
  logic [2:0]  funct3D;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [4:0]  Rs1E, Rs2E, RdE, RdM;
  logic [1:0]  ResultSrcE, ResultSrcM;
  logic        PCSrcE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [2:0]  funct3M;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .funct3D(funct3D), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .funct3M(funct3M)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: one instruction record per stage
  typedef struct packed {
    logic rw, mw, j, b, asrc;
    logic [1:0] rs;
    logic [3:0] ac;
    logic [2:0] f3;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0] r1, r2, rd;
  } e_t;

  typedef struct packed {
    logic rw, mw;
    logic [1:0] rs;
    logic [31:0] alu, wd, pc4;
    logic [4:0] rd;
    logic [2:0] f3;
  } m_t;

  e_t me;
  m_t mm;

  function automatic e_t d_inputs();
    e_t e;
    e.rw = RegWriteD; e.mw = MemWriteD; e.j = JumpD; e.b = BranchD; e.asrc = ALUSrcD;
    e.rs = ResultSrcD; e.ac = ALUControlD; e.f3 = funct3D;
    e.rd1 = RD1D; e.rd2 = RD2D; e.pc = PCD; e.pc4 = PCPlus4D; e.imm = ImmExtD;
    e.r1 = Rs1D; e.r2 = Rs2D; e.rd = RdD;
    return e;
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return mm.alu;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    longint sa, sb;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return ({32{a[31]}} << (32 - sh)) | (a >> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check E-stage combinational outputs, advance model, check registers
  task automatic step();
    logic [31:0] a, wd, b;
    e_t ne;
    m_t nm;
    #1;
    a  = fwd(ForwardAE, me.rd1);
    wd = fwd(ForwardBE, me.rd2);
    b  = me.asrc ? me.imm : wd;
    check("PCSrcE", {31'd0, PCSrcE}, {31'd0, me.j | (me.b & ref_cond(me.f3, a, b))});
    check("PCTargetE", PCTargetE, me.pc + me.imm);
    nm = '0;
    if (!StallE && !reset) begin
      nm.rw = me.rw; nm.mw = me.mw; nm.rs = me.rs; nm.alu = ref_alu(me.ac, a, b);
      nm.wd = wd; nm.pc4 = me.pc4; nm.rd = me.rd; nm.f3 = me.f3;
    end
    if (reset || FlushE) ne = '0;
    else if (StallE)     ne = me;
    else                 ne = d_inputs();
    @(posedge clk);
    me = ne;
    mm = nm;
    #1;
    check("Rs1E", {27'd0, Rs1E}, {27'd0, me.r1});
    check("Rs2E", {27'd0, Rs2E}, {27'd0, me.r2});
    check("RdE", {27'd0, RdE}, {27'd0, me.rd});
    check("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, me.rs});
    check("RegWriteM", {31'd0, RegWriteM}, {31'd0, mm.rw});
    check("MemWriteM", {31'd0, MemWriteM}, {31'd0, mm.mw});
    check("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, mm.rs});
    check("ALUResultM", ALUResultM, mm.alu);
    check("WriteDataM", WriteDataM, mm.wd);
    check("PCPlus4M", PCPlus4M, mm.pc4);
    check("RdM", {27'd0, RdM}, {27'd0, mm.rd});
    check("funct3M", {29'd0, funct3M}, {29'd0, mm.f3});
    @(negedge clk);
  endtask

  task automatic set_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic asrc, input logic [31:0] imm);
    ALUControlD = c; RD1D = a; RD2D = b; ALUSrcD = asrc; ImmExtD = imm;
  endtask

  task automatic fwd_test(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    set_alu(4'd0, 32'h54, 32'h0, 1'b1, 32'h1);  // producer: 0x55
    step();
    set_alu(4'd0, 32'h11, 32'h0, 1'b1, 32'h1);  // consumer: rs1 + 1
    step();
    ForwardAE = sel;
    ResultW   = 32'h77;
    check({tag, "_prev"}, ALUResultM, 32'h55);
    step();
    check(tag, ALUResultM, exp);
    ForwardAE = 2'd0;
  endtask

  task automatic randomize_inputs();
    reset      = ($urandom_range(0, 31) == 0);
    StallE     = ($urandom_range(0, 5) == 0);
    FlushE     = ($urandom_range(0, 7) == 0);
    RegWriteD  = 1'($urandom); MemWriteD = 1'($urandom);
    JumpD      = ($urandom_range(0, 7) == 0);
    BranchD    = 1'($urandom); ALUSrcD = 1'($urandom);
    ResultSrcD = 2'($urandom); ALUControlD = 4'($urandom); funct3D = 3'($urandom);
    RD1D       = $urandom;
    RD2D       = ($urandom_range(0, 3) == 0) ? RD1D : $urandom;
    PCD        = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
    Rs1D       = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    ForwardAE  = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
  endtask

  initial begin
    // Reset with nonzero decode inputs
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; BranchD = 1'b1; ALUSrcD = 1'b0;
    ResultSrcD = 2'd1; ALUControlD = 4'd0; funct3D = 3'd2;
    RD1D = 32'h1234; RD2D = 32'h10; PCD = 32'h40; PCPlus4D = 32'h44; ImmExtD = 32'h8;
    Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd7;
    ForwardAE = 2'd0; ForwardBE = 2'd0; ResultW = 32'h0;
    me = '0;
    mm = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    step();
    step();
    check("rst_RdE", {27'd0, RdE}, 32'd0);
    check("rst_RdM", {27'd0, RdM}, 32'd0);
    check("rst_PCSrcE", {31'd0, PCSrcE}, 32'd0);
    check("rst_ALUResultM", ALUResultM, 32'd0);

    // Release reset: instruction on E after 1 edge, on M after 2
    reset = 1'b0;
    step();
    check("rel_RdE", {27'd0, RdE}, 32'd7);
    check("rel_RdM_early", {27'd0, RdM}, 32'd0);
    step();
    check("rel_RdM", {27'd0, RdM}, 32'd7);
    check("rel_ALUResultM", ALUResultM, 32'h1244);

    // ALU: sra, sub, add wrap
    JumpD = 1'b0; BranchD = 1'b0;
    set_alu(4'd8, 32'h8000_0010, 32'h4, 1'b0, 32'h0);
    step(); step();
    check("sra", ALUResultM, 32'hF800_0001);
    set_alu(4'd1, 32'h8000_0010, 32'h4, 1'b0, 32'h0);
    step(); step();
    check("sub", ALUResultM, 32'h8000_000C);
    set_alu(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0);
    step(); step();
    check("add_wrap", ALUResultM, 32'h0);

    // Forwarding
    fwd_test(2'd2, 32'h56, "fwd_mem");
    fwd_test(2'd1, 32'h78, "fwd_wb");
    fwd_test(2'd3, 32'h12, "fwd_rf");

    // Branches and target
    BranchD = 1'b1; funct3D = 3'b100;
    set_alu(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0);
    step();
    check("blt_taken", {31'd0, PCSrcE}, 32'd1);
    funct3D = 3'b110;
    step();
    check("bltu_not", {31'd0, PCSrcE}, 32'd0);
    PCD = 32'h100; ImmExtD = 32'hFFFF_FFF0;
    step();
    check("pc_target", PCTargetE, 32'h0F0);
    BranchD = 1'b0;

    // Stall then flush+stall on a jump
    JumpD = 1'b1; RegWriteD = 1'b1; RdD = 5'd5;
    step();
    StallE = 1'b1; JumpD = 1'b0; RdD = 5'd9;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_RdE", {27'd0, RdE}, 32'd5);
      check("stall_RegWriteM", {31'd0, RegWriteM}, 32'd0);
      check("stall_RdM", {27'd0, RdM}, 32'd0);
    end
    FlushE = 1'b1;
    step();
    check("flush_RdE", {27'd0, RdE}, 32'd0);
    check("flush_PCSrcE", {31'd0, PCSrcE}, 32'd0);
    StallE = 1'b0; FlushE = 1'b0;

    // Jump with link
    JumpD = 1'b1; PCPlus4D = 32'h204; ResultSrcD = 2'b10; RdD = 5'd1; RegWriteD = 1'b1;
    step();
    check("jal_PCSrcE", {31'd0, PCSrcE}, 32'd1);
    JumpD = 1'b0;
    step();
    check("jal_PCPlus4M", PCPlus4M, 32'h204);
    check("jal_RdM", {27'd0, RdM}, 32'd1);
    check("jal_RegWriteM", {31'd0, RegWriteM}, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage pipelined RV32I core, downstream of the decode stage where the ALU decoder produces the 4-bit ALU control code.
- Contains the ID/EX pipeline register (stall/flush), forwarding operand muxes, ALU, branch/jump resolution and the EX/MEM pipeline register.
- Feeds the memory stage and returns PCSrcE/PCTargetE to fetch and Rs1E/Rs2E/RdE/ResultSrcE to the hazard unit.

Parameters:
XLEN, 32, datapath width. Shift amount is SrcB[$clog2(XLEN)-1:0].

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
StallE  in  1  hold ID/EX contents
FlushE  in  1  load bubble into ID/EX
RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode control
ResultSrcD  in  2  result select (00 ALU, 01 mem, 10 PC+4)
ALUControlD  in  4  ALU decoder output
funct3D  in  3  branch condition select
RD1D, RD2D, PCD, PCPlus4D, ImmExtD  in  XLEN each  decode data
Rs1D, Rs2D, RdD  in  5 each  register addresses
ForwardAE, ForwardBE  in  2 each  forward select
ResultW  in  XLEN  writeback result
Rs1E, Rs2E, RdE  out  5 each  to hazard unit
ResultSrcE  out  2  to hazard unit (load-use detect)
PCSrcE  out  1  redirect fetch
PCTargetE  out  XLEN  PCE + ImmExtE
RegWriteM, MemWriteM  out  1 each  EX/MEM control
ResultSrcM  out  2  EX/MEM control
ALUResultM, WriteDataM, PCPlus4M  out  XLEN each  EX/MEM data
RdM  out  5  EX/MEM destination
funct3M  out  3  load/store width for memory stage

Behaviour:
- Reset is synchronous, active-high, on clk. It clears every ID/EX and EX/MEM register field to 0, so all registered outputs read 0 the cycle after reset is sampled. Reset mid-operation discards in-flight instructions.
- ID/EX update priority: reset > FlushE > StallE > load.
  - FlushE zeroes all ID/EX fields (bubble: RegWriteE=MemWriteE=JumpE=BranchE=0, RdE=0).
  - StallE holds all fields.
  - FlushE and StallE together: flush wins.
- EX/MEM has no stall or flush. It loads every cycle from the E stage. While StallE=1 it loads a bubble (RegWriteM=MemWriteM=0, RdM=0, data fields 0) so the held instruction is not duplicated.
- Forward mux, SrcAE from ForwardAE: 00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E.
- WriteDataE is selected the same way from ForwardBE/RD2E. SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU is combinational. Results are XLEN bits; wrap on overflow, no exceptions.
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor.
  - 0101 slt, signed, result 1 or 0.
  - 0110 sll; 0111 srl; 1000 sra by SrcB[4:0].
  - Any other code gives result 0.
- Branch condition, from funct3E on SrcAE vs SrcBE (post-forward):
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010/011 not taken.
- PCSrcE = JumpE | (BranchE & cond). It is combinational from E registers and forward inputs.
- PCTargetE = PCE + ImmExtE, wrapping.
- Latency: the D-stage value presented at edge n appears on the E outputs after edge n and on the M outputs after edge n+1.
- A bubble in E yields PCSrcE=0 and, one cycle later, a bubble in M.

Test Plan:
- Reset held 2 cycles with nonzero D inputs -> all M outputs 0, PCSrcE=0, RdE=0. Release reset -> the D instruction appears on E outputs after 1 edge and on M after 2.
- Add/sub/sra: RD1D=0x80000010, RD2D=0x00000004, ALUControlD=1000, ALUSrcD=0 -> ALUResultM=0xF8000001. ALUControlD=0001 -> ALUResultM=0x8000000C. ALUControlD=0000 with RD1D=0xFFFFFFFF, RD2D=1 -> 0x00000000.
- Forwarding: ALUResultM=0x55, ResultW=0x77, RD1D=0x11. ForwardAE=10 with add imm 1 -> ALUResultM=0x56. ForwardAE=01 -> 0x78. ForwardAE=11 -> 0x12.
- Branch: BranchD=1, funct3D=100, SrcA=0xFFFFFFFF, SrcB=1 -> PCSrcE=1. Same operands with funct3D=110 -> PCSrcE=0. PCD=0x100, ImmExtD=0xFFFFFFF0 -> PCTargetE=0x0F0.
- Stall/flush: StallE=1 for 2 cycles -> E outputs unchanged and RegWriteM=0, RdM=0 in each stalled cycle. FlushE=1 with StallE=1 -> RdE=0 and PCSrcE=0 next cycle.
- JumpD=1 with PCPlus4D=0x204, ResultSrcD=10, RdD=1 -> PCSrcE=1, then PCPlus4M=0x204, RdM=1, RegWriteM=1.
